id_ex_stage: RTL and testbench

ID/EX pipeline stage that directly feeds the ALU. It registers decoded operands and control from the decode stage and decodes the 4-bit ALU operation code. It resolves data hazards with EX/MEM and MEM/WB forwarding onto `srcA`/`srcB`, detects load-use hazards, and supports stall and flush.

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/alu_decoder.sv | 40 ++++
 rtl/id_ex_stage.sv | 149 ++++++++++++++
 tb/tb_id_ex_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared definitions for the integer pipeline: datapath width, ALU_op
// operation-class encodings, funct3 values the ALU decoder cares about,
// and the 4-bit ALU control codes driven into the execute stage.
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   // ALU_op operation classes produced by the main decoder
   typedef enum logic [1:0] {
      ALU_OP_MEM     = 2'b00,  // loads/stores: address add
      ALU_OP_BRANCH  = 2'b01,  // branches: compare by subtract
      ALU_OP_FUNCT   = 2'b10,  // R/I arithmetic: decode funct3/funct7
      ALU_OP_DEFAULT = 2'b11   // anything else: add
   } alu_op_e;

   // ALU control codes
   typedef enum logic [3:0] {
      AND_OP    = 4'b0000,
      OR_OP     = 4'b0001,
      ADD       = 4'b0010,
      SUBTRACT  = 4'b0110,
      LESS_THAN = 4'b0111
   } alu_ctrl_e;

   // funct3 values that select a non-ADD operation
   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder
// Combinational translation of the operation class and funct fields into
// the 4-bit ALU control code.
// Ports:
//   ALU_op      in  2  operation class
//   funct3      in  3  instruction funct3
//   funct7_5    in  1  instruction bit 30
//   is_rtype    in  1  instruction is R-type
//   ALU_control out 4  ALU operation code
module alu_decoder
   import riscv_pkg::*;
(
   input  logic [1:0] ALU_op,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       is_rtype,
   output logic [3:0] ALU_control
);

   always_comb begin
      ALU_control = ADD;
      case (ALU_op)
         ALU_OP_MEM:    ALU_control = ADD;
         ALU_OP_BRANCH: ALU_control = SUBTRACT;
         ALU_OP_FUNCT: begin
            case (funct3)
               // bit 30 only means SUB for register-register ops; on
               // ADDI it is just part of the immediate
               F3_ADD_SUB: ALU_control = (is_rtype && funct7_5) ? SUBTRACT : ADD;
               F3_AND:     ALU_control = AND_OP;
               F3_OR:      ALU_control = OR_OP;
               F3_SLT:     ALU_control = LESS_THAN;
               default:    ALU_control = ADD;
            endcase
         end
         default:       ALU_control = ADD;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline register feeding the ALU. Captures decoded operands and
// control, decodes the ALU control code before the register, forwards
// EX/MEM and MEM/WB results onto the operands, and raises hazard_stall on
// a load-use dependency (inserting one bubble).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   stall, flush               hold all registers / load a bubble
//   in_valid                   decode-stage instruction valid
//   rs1_data, rs2_data, imm    register read data, sign-extended immediate
//   rs1_addr, rs2_addr, rd_addr register indices
//   ALU_src, ALU_op, funct3, funct7_5, is_rtype   ALU selection/decode
//   reg_write, mem_read, mem_write, mem_to_reg    control bits
//   exmem_*, memwb_*           forwarding sources
//   out_valid                  stage holds a real instruction
//   srcA, srcB, store_data     forwarded ALU operands / store data
//   ALU_control                registered ALU code
//   rd_out, *_out              registered destination and control bits
//   hazard_stall               load-use hazard, upstream must hold
module id_ex_stage
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = riscv_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            flush,
   input  logic            in_valid,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [XLEN-1:0] imm,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   input  logic [4:0]      rd_addr,
   input  logic            ALU_src,
   input  logic [1:0]      ALU_op,
   input  logic [2:0]      funct3,
   input  logic            funct7_5,
   input  logic            is_rtype,
   input  logic            reg_write,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic            mem_to_reg,
   input  logic            exmem_reg_write,
   input  logic [4:0]      exmem_rd,
   input  logic [XLEN-1:0] exmem_result,
   input  logic            memwb_reg_write,
   input  logic [4:0]      memwb_rd,
   input  logic [XLEN-1:0] memwb_result,
   output logic            out_valid,
   output logic [XLEN-1:0] srcA,
   output logic [XLEN-1:0] srcB,
   output logic [3:0]      ALU_control,
   output logic [XLEN-1:0] store_data,
   output logic [4:0]      rd_out,
   output logic            reg_write_out,
   output logic            mem_read_out,
   output logic            mem_write_out,
   output logic            mem_to_reg_out,
   output logic            hazard_stall
);

   logic [3:0]      alu_ctrl_next;

   logic [XLEN-1:0] rs1_data_q;
   logic [XLEN-1:0] rs2_data_q;
   logic [XLEN-1:0] imm_q;
   logic [4:0]      rs1_addr_q;
   logic [4:0]      rs2_addr_q;
   logic            alu_src_q;

   logic [XLEN-1:0] fwd_rs1;
   logic [XLEN-1:0] fwd_rs2;

   alu_decoder u_alu_decoder (
      .ALU_op      (ALU_op),
      .funct3      (funct3),
      .funct7_5    (funct7_5),
      .is_rtype    (is_rtype),
      .ALU_control (alu_ctrl_next)
   );

   // Load-use: the load in this stage has not produced data yet, so the
   // dependent instruction must wait one cycle and pick it up from MEM/WB.
   always_comb begin
      hazard_stall = out_valid && mem_read_out && in_valid &&
                     (rd_out != 5'd0) &&
                     ((rd_out == rs1_addr) || (rd_out == rs2_addr)) &&
                     !stall && !flush;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush || (!stall && hazard_stall)) begin
         out_valid      <= 1'b0;
         rs1_data_q     <= '0;
         rs2_data_q     <= '0;
         imm_q          <= '0;
         rs1_addr_q     <= '0;
         rs2_addr_q     <= '0;
         rd_out         <= '0;
         alu_src_q      <= 1'b0;
         ALU_control    <= ADD;
         reg_write_out  <= 1'b0;
         mem_read_out   <= 1'b0;
         mem_write_out  <= 1'b0;
         mem_to_reg_out <= 1'b0;
      end else if (!stall) begin
         out_valid      <= in_valid;
         rs1_data_q     <= rs1_data;
         rs2_data_q     <= rs2_data;
         imm_q          <= imm;
         rs1_addr_q     <= rs1_addr;
         rs2_addr_q     <= rs2_addr;
         rd_out         <= rd_addr;
         alu_src_q      <= ALU_src;
         ALU_control    <= alu_ctrl_next;
         reg_write_out  <= reg_write;
         mem_read_out   <= mem_read;
         mem_write_out  <= mem_write;
         mem_to_reg_out <= mem_to_reg;
      end
   end

   // rs1 forwarding: EX/MEM is younger than MEM/WB, so it takes priority
   always_comb begin
      fwd_rs1 = rs1_data_q;
      if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rs1_addr_q))
         fwd_rs1 = exmem_result;
      else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs1_addr_q))
         fwd_rs1 = memwb_result;
   end

   // rs2 forwarding: same priority as rs1
   always_comb begin
      fwd_rs2 = rs2_data_q;
      if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rs2_addr_q))
         fwd_rs2 = exmem_result;
      else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs2_addr_q))
         fwd_rs2 = memwb_result;
   end

   always_comb begin
      srcA       = fwd_rs1;
      store_data = fwd_rs2;
      srcB       = alu_src_q ? imm_q : fwd_rs2;
   end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n, stall, flush, in_valid;
   logic [31:0] rs1_data, rs2_data, imm;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic        ALU_src;
   logic [1:0]  ALU_op;
   logic [2:0]  funct3;
   logic        funct7_5, is_rtype;
   logic        reg_write, mem_read, mem_write, mem_to_reg;
   logic        exmem_reg_write, memwb_reg_write;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_result, memwb_result;
   logic        out_valid;
   logic [31:0] srcA, srcB, store_data;
   logic [3:0]  ALU_control;
   logic [4:0]  rd_out;
   logic        reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out;
   logic        hazard_stall;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
      .ALU_src(ALU_src), .ALU_op(ALU_op), .funct3(funct3), .funct7_5(funct7_5),
      .is_rtype(is_rtype), .reg_write(reg_write), .mem_read(mem_read),
      .mem_write(mem_write), .mem_to_reg(mem_to_reg),
      .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .out_valid(out_valid), .srcA(srcA), .srcB(srcB), .ALU_control(ALU_control),
      .store_data(store_data), .rd_out(rd_out), .reg_write_out(reg_write_out),
      .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
      .mem_to_reg_out(mem_to_reg_out), .hazard_stall(hazard_stall)
   );

   // inputs change 1 time unit after the rising edge; outputs are read then
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      stall = 0; flush = 0; in_valid = 0;
      rs1_data = '0; rs2_data = '0; imm = '0;
      rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
      ALU_src = 0; ALU_op = 2'b00; funct3 = 3'b000; funct7_5 = 0; is_rtype = 0;
      reg_write = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0;
      exmem_reg_write = 0; exmem_rd = '0; exmem_result = '0;
      memwb_reg_write = 0; memwb_rd = '0; memwb_result = '0;
   endtask

   task automatic test_reset();
      clear_inputs();
      // garbage on the inputs while reset and stall are both asserted
      rst_n = 0; stall = 1; in_valid = 1; rs1_data = 32'hDEAD; rd_addr = 5'd9;
      reg_write = 1; mem_read = 1; ALU_op = 2'b01;
      step(); step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      total++; if (ALU_control !== 4'b0010) begin bad++; $display("FAIL reset_aluctl got=%b exp=0010", ALU_control); end
      clear_inputs();
      rst_n = 1;
      step();
      total++; if (srcA !== 32'd0 || srcB !== 32'd0 || store_data !== 32'd0) begin
         bad++; $display("FAIL rel_operands got srcA=%h srcB=%h sd=%h exp=0", srcA, srcB, store_data); end
      total++; if (ALU_control !== 4'b0010) begin bad++; $display("FAIL rel_aluctl got=%b exp=0010", ALU_control); end
      total++; if (rd_out !== 5'd0 || reg_write_out !== 0 || mem_read_out !== 0 ||
                   mem_write_out !== 0 || mem_to_reg_out !== 0) begin
         bad++; $display("FAIL rel_ctrl got rd=%0d ctl=%b%b%b%b exp=0", rd_out,
                         reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out); end
      total++; if (out_valid !== 0 || hazard_stall !== 0) begin
         bad++; $display("FAIL rel_valid got v=%b hz=%b exp=0", out_valid, hazard_stall); end
   endtask

   task automatic test_rtype_sub();
      clear_inputs();
      in_valid = 1; ALU_op = 2'b10; funct3 = 3'b000; funct7_5 = 1; is_rtype = 1;
      rs1_addr = 5'd1; rs2_addr = 5'd2; rd_addr = 5'd3; rs1_data = 32'd5; rs2_data = 32'd3;
      reg_write = 1;
      step();
      total++; if (ALU_control !== 4'b0110) begin bad++; $display("FAIL sub_aluctl got=%b exp=0110", ALU_control); end
      total++; if (srcA !== 32'd5 || srcB !== 32'd3) begin
         bad++; $display("FAIL sub_operands got srcA=%0d srcB=%0d exp 5 3", srcA, srcB); end
      total++; if (out_valid !== 1 || rd_out !== 5'd3 || reg_write_out !== 1) begin
         bad++; $display("FAIL sub_regs got v=%b rd=%0d rw=%b exp 1 3 1", out_valid, rd_out, reg_write_out); end
   endtask

   task automatic test_alu_decode();
      // {ALU_op, funct3, funct7_5, is_rtype} -> expected code
      logic [1:0] ops [9]  = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10};
      logic [2:0] f3s [9]  = '{3'b000, 3'b000, 3'b000, 3'b111, 3'b110, 3'b010, 3'b100, 3'b111, 3'b000};
      logic       f7s [9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic       rts [9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [3:0] exps [9] = '{4'b0010, 4'b0110, 4'b0010, 4'b0000, 4'b0001, 4'b0111,
                               4'b0010, 4'b0010, 4'b0010};
      clear_inputs();
      in_valid = 1;
      for (int i = 0; i < 9; i++) begin
         ALU_op = ops[i]; funct3 = f3s[i]; funct7_5 = f7s[i]; is_rtype = rts[i];
         step();
         total++; if (ALU_control !== exps[i]) begin
            bad++; $display("FAIL decode_%0d got=%b exp=%b", i, ALU_control, exps[i]); end
      end
   endtask

   task automatic test_forwarding();
      clear_inputs();
      in_valid = 1; rs1_addr = 5'd7; rs1_data = 32'h11; rs2_addr = 5'd8; rs2_data = 32'h22;
      step();
      exmem_reg_write = 1; exmem_rd = 5'd7; exmem_result = 32'hAA;
      memwb_reg_write = 1; memwb_rd = 5'd7; memwb_result = 32'hBB;
      #1;
      total++; if (srcA !== 32'hAA) begin bad++; $display("FAIL fwd_both got=%h exp=aa", srcA); end
      total++; if (srcB !== 32'h22) begin bad++; $display("FAIL fwd_rs2_none got=%h exp=22", srcB); end
      exmem_reg_write = 0;
      #1;
      total++; if (srcA !== 32'hBB) begin bad++; $display("FAIL fwd_memwb got=%h exp=bb", srcA); end
      memwb_reg_write = 0;
      #1;
      total++; if (srcA !== 32'h11) begin bad++; $display("FAIL fwd_none got=%h exp=11", srcA); end
      exmem_reg_write = 1; exmem_rd = 5'd8;
      #1;
      total++; if (srcB !== 32'hAA || store_data !== 32'hAA || srcA !== 32'h11) begin
         bad++; $display("FAIL fwd_rs2 got srcB=%h sd=%h srcA=%h exp aa aa 11", srcB, store_data, srcA); end
      // x0 must never be forwarded
      clear_inputs();
      in_valid = 1; rs1_addr = 5'd0; rs1_data = 32'h33;
      step();
      exmem_reg_write = 1; exmem_rd = 5'd0; exmem_result = 32'hAA;
      memwb_reg_write = 1; memwb_rd = 5'd0; memwb_result = 32'hBB;
      #1;
      total++; if (srcA !== 32'h33) begin bad++; $display("FAIL fwd_x0 got=%h exp=33", srcA); end
   endtask

   task automatic test_load_use();
      clear_inputs();
      in_valid = 1; mem_read = 1; reg_write = 1; mem_to_reg = 1; rd_addr = 5'd4; rs1_addr = 5'd1;
      step();
      // dependent add r5 = r4 + r0
      mem_read = 0; mem_to_reg = 0; rd_addr = 5'd5; rs1_addr = 5'd4; rs2_addr = 5'd0;
      stall = 1;
      #1;
      total++; if (hazard_stall !== 0) begin bad++; $display("FAIL lu_masked got=%b exp=0", hazard_stall); end
      stall = 0;
      #1;
      total++; if (hazard_stall !== 1) begin bad++; $display("FAIL lu_detect got=%b exp=1", hazard_stall); end
      step();
      total++; if (out_valid !== 0 || reg_write_out !== 0 || hazard_stall !== 0) begin
         bad++; $display("FAIL lu_bubble got v=%b rw=%b hz=%b exp 0 0 0", out_valid, reg_write_out, hazard_stall); end
      // load now in MEM/WB; dependent instruction enters and forwards from it
      rs1_data = 32'h0; memwb_reg_write = 1; memwb_rd = 5'd4; memwb_result = 32'h1234;
      step();
      total++; if (out_valid !== 1 || rd_out !== 5'd5 || srcA !== 32'h1234 || hazard_stall !== 0) begin
         bad++; $display("FAIL lu_resume got v=%b rd=%0d srcA=%h hz=%b exp 1 5 1234 0",
                         out_valid, rd_out, srcA, hazard_stall); end
   endtask

   task automatic test_imm_select();
      clear_inputs();
      in_valid = 1; ALU_src = 1; imm = 32'hFFFF_FFFC; rs2_addr = 5'd9; rs2_data = 32'h55; mem_write = 1;
      step();
      total++; if (srcB !== 32'hFFFF_FFFC || store_data !== 32'h55) begin
         bad++; $display("FAIL imm_plain got srcB=%h sd=%h exp fffffffc 55", srcB, store_data); end
      exmem_reg_write = 1; exmem_rd = 5'd9; exmem_result = 32'h77;
      #1;
      total++; if (srcB !== 32'hFFFF_FFFC || store_data !== 32'h77 || mem_write_out !== 1) begin
         bad++; $display("FAIL imm_fwd got srcB=%h sd=%h mw=%b exp fffffffc 77 1", srcB, store_data, mem_write_out); end
   endtask

   task automatic test_flush_stall();
      clear_inputs();
      in_valid = 1; rd_addr = 5'd6; reg_write = 1; ALU_op = 2'b01; rs1_addr = 5'd2; rs1_data = 32'h10;
      step();
      // stall with different inputs: everything must hold
      stall = 1; rd_addr = 5'd9; rs1_data = 32'h99; ALU_op = 2'b10; funct3 = 3'b111; reg_write = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         total++; if (out_valid !== 1 || rd_out !== 5'd6 || srcA !== 32'h10 ||
                      ALU_control !== 4'b0110 || reg_write_out !== 1) begin
            bad++; $display("FAIL stall_hold_%0d got v=%b rd=%0d srcA=%h ctl=%b rw=%b exp 1 6 10 0110 1",
                            c, out_valid, rd_out, srcA, ALU_control, reg_write_out); end
      end
      flush = 1;
      step();
      total++; if (out_valid !== 0 || ALU_control !== 4'b0010 || rd_out !== 5'd0 ||
                   srcA !== 32'd0 || reg_write_out !== 0) begin
         bad++; $display("FAIL flush_stall got v=%b ctl=%b rd=%0d srcA=%h rw=%b exp 0 0010 0 0 0",
                         out_valid, ALU_control, rd_out, srcA, reg_write_out); end
   endtask

   initial begin
      rst_n = 0;
      clear_inputs();
      test_reset();
      test_rtype_sub();
      test_alu_decode();
      test_forwarding();
      test_load_use();
      test_imm_select();
      test_flush_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
